tlb_walk: RTL and testbench

//  Parametrised fully-associative data TLB with an integrated miss handler.
//  It translates user-mode virtual addresses through ENTRIES cached VPN->PPN mappings.
//  On a miss it requests a page-table walk, refills itself and replays the response.

---
 rtl/tlb_walk.sv | 167 ++++++++++++++++
 tb/tb_tlb_walk.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tlb_walk.sv
// Fully-associative data TLB with page-walk miss handler and supervisor bypass.
// Hit/bypass response one cycle after accept; misses hold off new requests (req_ready_o low) until the walk returns.
module tlb_walk #(
  parameter int ENTRIES = 16,
  parameter int VA_W    = 32,
  parameter int PA_W    = 20,
  parameter int PAGE_W  = 12,
  parameter int AGE_W   = 4,
  localparam int VPN_W  = VA_W - PAGE_W,
  localparam int PPN_W  = PA_W - PAGE_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mode_i,
  input  logic             req_valid_i,
  input  logic [VA_W-1:0]  req_vaddr_i,
  output logic             req_ready_o,
  output logic             resp_valid_o,
  output logic [PA_W-1:0]  resp_paddr_o,
  output logic             resp_fault_o,
  output logic             walk_req_o,
  output logic [VPN_W-1:0] walk_vpn_o,
  input  logic             walk_ack_i,
  input  logic [PPN_W-1:0] walk_ppn_i,
  input  logic             walk_fault_i,
  input  logic             flush_i,
  input  logic             inv_valid_i,
  input  logic [VPN_W-1:0] inv_vpn_i
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  typedef enum logic {IDLE, WALK} state_e;

  state_e              state_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [AGE_W-1:0]    age_q [ENTRIES];
  logic [VPN_W-1:0]    vpn_q [ENTRIES];
  logic [PPN_W-1:0]    ppn_q [ENTRIES];
  logic [PAGE_W-1:0]   off_q;
  logic                resp_valid_q, resp_fault_q, walk_req_q;
  logic [PA_W-1:0]     resp_paddr_q;
  logic [VPN_W-1:0]    walk_vpn_q;

  logic [VPN_W-1:0]    req_vpn;
  logic [PAGE_W-1:0]   req_off;
  logic                accept, hit, found_inv, ins_en;
  logic [IDX_W-1:0]    hit_idx, vic_idx;
  logic [AGE_W-1:0]    max_age;

  assign req_vpn      = req_vaddr_i[VA_W-1:PAGE_W];
  assign req_off      = req_vaddr_i[PAGE_W-1:0];
  assign req_ready_o  = (state_q == IDLE) && rst_ni;
  assign accept       = req_valid_i && req_ready_o;
  assign ins_en       = (state_q == WALK) && walk_ack_i && !walk_fault_i && !flush_i;

  assign resp_valid_o = resp_valid_q;
  assign resp_paddr_o = resp_paddr_q;
  assign resp_fault_o = resp_fault_q;
  assign walk_req_o   = walk_req_q;
  assign walk_vpn_o   = walk_vpn_q;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!hit && valid_q[i] && (vpn_q[i] == req_vpn)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Prefer the first free slot; otherwise the oldest, strict '>' keeps ties at the lowest index.
  always_comb begin
    found_inv = 1'b0;
    vic_idx   = '0;
    max_age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!found_inv && !valid_q[i]) begin
        found_inv = 1'b1;
        vic_idx   = IDX_W'(i);
      end
    end
    if (!found_inv) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (age_q[i] > max_age) begin
          max_age = age_q[i];
          vic_idx = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ins_en) begin
      vpn_q[vic_idx] <= walk_vpn_q;
      ppn_q[vic_idx] <= walk_ppn_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
      off_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_paddr_q <= '0;
      walk_req_q   <= 1'b0;
      walk_vpn_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;

      for (int i = 0; i < ENTRIES; i++) begin
        if (inv_valid_i && valid_q[i] && (vpn_q[i] == inv_vpn_i)) valid_q[i] <= 1'b0;
      end
      if (flush_i) valid_q <= '0;

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (mode_i) begin
              resp_valid_q <= 1'b1;
              resp_paddr_q <= req_vaddr_i[PA_W-1:0];
            end else begin
              for (int i = 0; i < ENTRIES; i++) begin
                if (valid_q[i]) begin
                  if (hit && (hit_idx == IDX_W'(i)))  age_q[i] <= '0;
                  else if (age_q[i] != AGE_MAX)       age_q[i] <= age_q[i] + AGE_W'(1);
                end
              end
              if (hit) begin
                resp_valid_q <= 1'b1;
                resp_paddr_q <= {ppn_q[hit_idx], req_off};
              end else begin
                walk_req_q <= 1'b1;
                walk_vpn_q <= req_vpn;
                off_q      <= req_off;
                state_q    <= WALK;
              end
            end
          end
        end
        WALK: begin
          if (walk_ack_i) begin
            walk_req_q   <= 1'b0;
            state_q      <= IDLE;
            resp_valid_q <= 1'b1;
            resp_fault_q <= walk_fault_i;
            resp_paddr_q <= walk_fault_i ? '0 : {walk_ppn_i, off_q};
            // A flush in the ack cycle still answers the request but must not leave a stale entry.
            if (ins_en) begin
              valid_q[vic_idx] <= 1'b1;
              age_q[vic_idx]   <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_walk.sv
// Directed bench for tlb_walk: vector table plus hand sequences for walk, flush, invalidate, LRU and reset.
module tb_tlb_walk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, req_valid, req_ready;
  logic [31:0] req_vaddr;
  logic        resp_valid, resp_fault;
  logic [19:0] resp_paddr;
  logic        walk_req;
  logic [19:0] walk_vpn;
  logic        walk_ack, walk_fault;
  logic [7:0]  walk_ppn;
  logic        flush, inv_valid;
  logic [19:0] inv_vpn;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tlb_walk dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode),
    .req_valid_i(req_valid), .req_vaddr_i(req_vaddr), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_paddr_o(resp_paddr), .resp_fault_o(resp_fault),
    .walk_req_o(walk_req), .walk_vpn_o(walk_vpn),
    .walk_ack_i(walk_ack), .walk_ppn_i(walk_ppn), .walk_fault_i(walk_fault),
    .flush_i(flush), .inv_valid_i(inv_valid), .inv_vpn_i(inv_vpn)
  );

  typedef struct {
    logic        m;
    logic [31:0] va;
    logic        exp_hit;
    logic [7:0]  ppn;
    logic        flt;
    logic [19:0] exp_pa;
    logic        exp_flt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One request; on an expected miss, serve the walk after one extra wait cycle.
  task automatic lookup(input logic m, input logic [31:0] va, input logic exp_hit,
                        input logic [7:0] ppn, input logic flt, input logic [19:0] exp_pa,
                        input logic exp_flt, input logic fl_ack, input string tag);
    logic [19:0] vpn;
    vpn = va[31:12];
    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    mode = m; req_vaddr = va; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_hit) begin
      check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " paddr"}, 32'(resp_paddr), 32'(exp_pa));
      check({tag, " fault"}, 32'(resp_fault), 32'd0);
      check({tag, " no walk"}, 32'(walk_req), 32'd0);
    end else begin
      check({tag, " no resp on miss"}, 32'(resp_valid), 32'd0);
      check({tag, " walk_req"}, 32'(walk_req), 32'd1);
      check({tag, " walk_vpn"}, 32'(walk_vpn), 32'(vpn));
      check({tag, " busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      check({tag, " walk_req held"}, 32'(walk_req), 32'd1);
      walk_ack = 1'b1; walk_ppn = ppn; walk_fault = flt; flush = fl_ack;
      @(negedge clk);
      walk_ack = 1'b0; walk_fault = 1'b0; flush = 1'b0;
      check({tag, " walk resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " walk paddr"}, 32'(resp_paddr), 32'(exp_pa));
      check({tag, " walk fault"}, 32'(resp_fault), 32'(exp_flt));
      check({tag, " walk_req drop"}, 32'(walk_req), 32'd0);
      check({tag, " ready again"}, 32'(req_ready), 32'd1);
    end
  endtask

  task automatic pulse_inv(input logic [19:0] vpn);
    @(negedge clk);
    inv_valid = 1'b1; inv_vpn = vpn;
    @(negedge clk);
    inv_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; req_valid = 1'b0; req_vaddr = '0;
    walk_ack = 1'b0; walk_fault = 1'b0; walk_ppn = '0;
    flush = 1'b0; inv_valid = 1'b0; inv_vpn = '0;

    vecs[0] = '{1'b0, 32'h00012ABC, 1'b0, 8'h34, 1'b0, 20'h34ABC, 1'b0};
    vecs[1] = '{1'b0, 32'h00012ABC, 1'b1, 8'h00, 1'b0, 20'h34ABC, 1'b0};
    vecs[2] = '{1'b0, 32'h00012123, 1'b1, 8'h00, 1'b0, 20'h34123, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF5678, 1'b1, 8'h00, 1'b0, 20'hF5678, 1'b0};
    vecs[4] = '{1'b1, 32'h00012ABC, 1'b1, 8'h00, 1'b0, 20'h12ABC, 1'b0};
    vecs[5] = '{1'b0, 32'h00099000, 1'b0, 8'h55, 1'b1, 20'h00000, 1'b1};
    vecs[6] = '{1'b0, 32'h00099000, 1'b0, 8'h07, 1'b0, 20'h07000, 1'b0};
    vecs[7] = '{1'b0, 32'h00099FFF, 1'b1, 8'h00, 1'b0, 20'h07FFF, 1'b0};

    #12;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_paddr", 32'(resp_paddr), 32'd0);
    check("reset resp_fault", 32'(resp_fault), 32'd0);
    check("reset walk_req", 32'(walk_req), 32'd0);
    check("reset walk_vpn", 32'(walk_vpn), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      lookup(vecs[i].m, vecs[i].va, vecs[i].exp_hit, vecs[i].ppn, vecs[i].flt,
             vecs[i].exp_pa, vecs[i].exp_flt, 1'b0, $sformatf("vec%0d", i));

    // Back-to-back hits: one response per cycle.
    @(negedge clk);
    mode = 1'b0; req_valid = 1'b1; req_vaddr = 32'h00012001;
    @(negedge clk);
    req_vaddr = 32'h00099002;
    check("b2b first valid", 32'(resp_valid), 32'd1);
    check("b2b first paddr", 32'(resp_paddr), 32'h34001);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b second valid", 32'(resp_valid), 32'd1);
    check("b2b second paddr", 32'(resp_paddr), 32'h07002);

    // Flush coinciding with walk_ack: response delivered, nothing inserted.
    lookup(1'b0, 32'h00055123, 1'b0, 8'h11, 1'b0, 20'h11123, 1'b0, 1'b1, "flush_ack");
    lookup(1'b0, 32'h00055123, 1'b0, 8'h12, 1'b0, 20'h12123, 1'b0, 1'b0, "after flush same");
    lookup(1'b0, 32'h00012ABC, 1'b0, 8'h34, 1'b0, 20'h34ABC, 1'b0, 1'b0, "after flush other");

    pulse_inv(20'h00012);
    pulse_inv(20'h00777);
    lookup(1'b0, 32'h00055456, 1'b1, 8'h00, 1'b0, 20'h12456, 1'b0, 1'b0, "inv nomatch keeps");
    lookup(1'b0, 32'h00012ABC, 1'b0, 8'h35, 1'b0, 20'h35ABC, 1'b0, 1'b0, "inv resident miss");

    // Lookup and invalidate in the same cycle: lookup still hits, later lookup misses.
    @(negedge clk);
    mode = 1'b0; req_valid = 1'b1; req_vaddr = 32'h00055789;
    inv_valid = 1'b1; inv_vpn = 20'h00055;
    @(negedge clk);
    req_valid = 1'b0; inv_valid = 1'b0;
    check("inv same-cycle hit", 32'(resp_valid), 32'd1);
    check("inv same-cycle paddr", 32'(resp_paddr), 32'h12789);
    lookup(1'b0, 32'h00055789, 1'b0, 8'h13, 1'b0, 20'h13789, 1'b0, 1'b0, "inv later miss");

    // Replacement: fill 16, touch VPN 0, miss VPN 16 must evict VPN 1.
    do_reset();
    for (int k = 0; k < 16; k++)
      lookup(1'b0, 32'(k) << 12, 1'b0, 8'(k + 'h40), 1'b0, {8'(k + 'h40), 12'h000},
             1'b0, 1'b0, $sformatf("fill%0d", k));
    lookup(1'b0, 32'h00000000, 1'b1, 8'h00, 1'b0, 20'h40000, 1'b0, 1'b0, "touch vpn0");
    lookup(1'b0, 32'h00010000, 1'b0, 8'h80, 1'b0, 20'h80000, 1'b0, 1'b0, "miss vpn16");
    lookup(1'b0, 32'h00001000, 1'b0, 8'h90, 1'b0, 20'h90000, 1'b0, 1'b0, "vpn1 evicted");
    lookup(1'b0, 32'h00010000, 1'b1, 8'h00, 1'b0, 20'h80000, 1'b0, 1'b0, "vpn16 hit");
    lookup(1'b0, 32'h00000000, 1'b1, 8'h00, 1'b0, 20'h40000, 1'b0, 1'b0, "vpn0 hit");
    lookup(1'b0, 32'h00003000, 1'b1, 8'h00, 1'b0, 20'h43000, 1'b0, 1'b0, "vpn3 hit");

    // Reset during a walk.
    @(negedge clk);
    mode = 1'b0; req_valid = 1'b1; req_vaddr = 32'h000AA000;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst-walk walk_req", 32'(walk_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst-walk walk_req drop", 32'(walk_req), 32'd0);
    check("rst-walk ready low", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst-walk no resp %0d", c), 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst-walk no late resp", 32'(resp_valid), 32'd0);
    lookup(1'b0, 32'h00010000, 1'b0, 8'h81, 1'b0, 20'h81000, 1'b0, 1'b0, "post-rst vpn16");
    lookup(1'b0, 32'h00000000, 1'b0, 8'h41, 1'b0, 20'h41000, 1'b0, 1'b0, "post-rst vpn0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
